m_axi_reg_master: RTL and testbench

- AXI initiator that turns single-word command requests from local control logic into single-beat AXI write or read transactions toward the s_axi_reg register slave.
- Returns one response per command: read data plus a status code.
- Sits between control/sequencer logic and the register file; only one transaction is outstanding at a time.

---
 rtl/m_axi_reg_pkg.sv | 30 +++
 rtl/m_axi_reg_if.sv | 49 ++++
 rtl/axi_wait_timer.sv | 28 ++
 rtl/m_axi_reg_master.sv | 171 +++++++++++++++++
 tb/tb_m_axi_reg_master.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/m_axi_reg_pkg.sv
// Shared types and constants for the single-beat AXI register master.
package m_axi_reg_pkg;

   localparam int unsigned TMR_W         = 16;
   localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_REQ,
      S_WR_RESP,
      S_RD_REQ,
      S_RD_DATA,
      S_RSP
   } state_e;

   typedef enum logic [1:0] {
      RSP_OK      = 2'b00,
      RSP_BUSERR  = 2'b01,
      RSP_IDERR   = 2'b10,
      RSP_TIMEOUT = 2'b11
   } status_e;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } cmd_t;

endpackage

// File: rtl/m_axi_reg_if.sv
// AXI channel bundle between the register master and the register slave.
interface m_axi_reg_if;

   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;

   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;

   logic [3:0]  arid;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;

   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [3:0]  rstrb;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output awid, awaddr, awvalid, input awready,
      output wid, wdata, wstrb, wlast, wvalid, input wready,
      output arid, araddr, arvalid, input arready,
      input  rid, rdata, rstrb, rlast, rvalid, output rready,
      input  bid, bresp, bvalid, output bready
   );

   modport slave (
      input  awid, awaddr, awvalid, output awready,
      input  wid, wdata, wstrb, wlast, wvalid, output wready,
      input  arid, araddr, arvalid, output arready,
      output rid, rdata, rstrb, rlast, rvalid, input rready,
      output bid, bresp, bvalid, input bready
   );

endinterface

// File: rtl/axi_wait_timer.sv
// Cycle counter bounding the wait for a B or R beat; expires on the last allowed cycle.
module axi_wait_timer
   import m_axi_reg_pkg::*;
(
   input  logic             clk,
   input  logic             areset,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [TMR_W-1:0] last_i,
   output logic             expire_o
);

   logic [TMR_W-1:0] cnt_q;

   // Count waiting cycles; clear takes priority so each wait starts from zero.
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expire_o = en_i && (cnt_q == last_i);

endmodule

// File: rtl/m_axi_reg_master.sv
// Turns local single-word commands into single-beat AXI reads/writes, one at a time.
module m_axi_reg_master
   import m_axi_reg_pkg::*;
#(
   parameter logic [3:0]  AXI_ID         = 4'h0,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic         clk,
   input  logic         areset,
   input  logic         cmd_valid_i,
   output logic         cmd_ready_o,
   input  logic         cmd_we_i,
   input  logic [31:0]  cmd_addr_i,
   input  logic [31:0]  cmd_wdata_i,
   input  logic [3:0]   cmd_wstrb_i,
   output logic         rsp_valid_o,
   input  logic         rsp_ready_i,
   output logic [31:0]  rsp_rdata_o,
   output logic [1:0]   rsp_status_o,
   output logic         stray_o,
   m_axi_reg_if.master  bus
);

   localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   state_e      state_q, state_d;
   cmd_t        cmd_q, cmd_d;
   logic        awvalid_q, awvalid_d;
   logic        wvalid_q, wvalid_d;
   logic        arvalid_q, arvalid_d;
   logic [31:0] rdata_q, rdata_d;
   status_e     status_q, status_d;
   logic        stray_q, stray_d;
   logic        tmr_clr, tmr_en, tmr_expire;
   logic        aw_done, w_done;
   logic        unused_sig;

   // rlast/rstrb carry nothing for single beats; the direction bit is implied by state.
   assign unused_sig = ^{bus.rstrb, bus.rlast, cmd_q.we};

   assign tmr_en = (state_q == S_WR_RESP) || (state_q == S_RD_DATA);

   axi_wait_timer u_timer (
      .clk      (clk),
      .areset   (areset),
      .clr_i    (tmr_clr),
      .en_i     (tmr_en),
      .last_i   (TMO_LAST),
      .expire_o (tmr_expire)
   );

   // A channel counts as done once its valid has dropped or handshakes this cycle.
   assign aw_done = !awvalid_q || bus.awready;
   assign w_done  = !wvalid_q  || bus.wready;

   // State and datapath registers; reset aborts any transaction in flight.
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         state_q   <= S_IDLE;
         cmd_q     <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rdata_q   <= '0;
         status_q  <= RSP_OK;
         stray_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         arvalid_q <= arvalid_d;
         rdata_q   <= rdata_d;
         status_q  <= status_d;
         stray_q   <= stray_d;
      end
   end

   // Next-state logic: accept, issue request, wait for beat or timeout, hold response.
   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      arvalid_d = arvalid_q;
      rdata_d   = rdata_q;
      status_d  = status_q;
      stray_d   = 1'b0;
      tmr_clr   = 1'b0;
      case (state_q)
         S_IDLE: begin
            stray_d = bus.bvalid || bus.rvalid;
            if (cmd_valid_i) begin
               cmd_d = '{we: cmd_we_i, addr: cmd_addr_i, wdata: cmd_wdata_i, wstrb: cmd_wstrb_i};
               if (cmd_we_i) begin
                  state_d   = S_WR_REQ;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = S_RD_REQ;
                  arvalid_d = 1'b1;
               end
            end
         end
         S_WR_REQ: begin
            if (awvalid_q && bus.awready) awvalid_d = 1'b0;
            if (wvalid_q && bus.wready)   wvalid_d  = 1'b0;
            if (aw_done && w_done) begin
               state_d = S_WR_RESP;
               tmr_clr = 1'b1;
            end
         end
         S_WR_RESP: begin
            if (bus.bvalid) begin
               state_d = S_RSP;
               rdata_d = '0;
               if (bus.bid != AXI_ID)                  status_d = RSP_IDERR;
               else if (bus.bresp != AXI_RESP_OKAY)    status_d = RSP_BUSERR;
               else                                    status_d = RSP_OK;
            end else if (tmr_expire) begin
               state_d  = S_RSP;
               rdata_d  = '0;
               status_d = RSP_TIMEOUT;
            end
         end
         S_RD_REQ: begin
            if (bus.arready) begin
               arvalid_d = 1'b0;
               state_d   = S_RD_DATA;
               tmr_clr   = 1'b1;
            end
         end
         S_RD_DATA: begin
            if (bus.rvalid) begin
               state_d  = S_RSP;
               rdata_d  = bus.rdata;
               status_d = (bus.rid != AXI_ID) ? RSP_IDERR : RSP_OK;
            end else if (tmr_expire) begin
               state_d  = S_RSP;
               rdata_d  = '0;
               status_d = RSP_TIMEOUT;
            end
         end
         S_RSP: begin
            if (rsp_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign cmd_ready_o  = (state_q == S_IDLE);
   assign rsp_valid_o  = (state_q == S_RSP);
   assign rsp_rdata_o  = rdata_q;
   assign rsp_status_o = status_q;
   assign stray_o      = stray_q;

   assign bus.awid    = AXI_ID;
   assign bus.awaddr  = cmd_q.addr;
   assign bus.awvalid = awvalid_q;
   assign bus.wid     = AXI_ID;
   assign bus.wdata   = cmd_q.wdata;
   assign bus.wstrb   = cmd_q.wstrb;
   assign bus.wlast   = 1'b1;
   assign bus.wvalid  = wvalid_q;
   assign bus.arid    = AXI_ID;
   assign bus.araddr  = cmd_q.addr;
   assign bus.arvalid = arvalid_q;
   assign bus.bready  = (state_q == S_IDLE) || (state_q == S_WR_RESP);
   assign bus.rready  = (state_q == S_IDLE) || (state_q == S_RD_DATA);

endmodule

// File: tb/tb_m_axi_reg_master.sv
// Directed bench for m_axi_reg_master with a hand-driven AXI slave.
module tb_m_axi_reg_master;

   logic        clk = 1'b0;
   logic        areset;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_status;
   logic        stray;

   int n_chk  = 0;
   int n_pass = 0;

   m_axi_reg_if bus();

   m_axi_reg_master #(.AXI_ID(4'h0), .TIMEOUT_CYCLES(8)) dut (
      .clk          (clk),
      .areset       (areset),
      .cmd_valid_i  (cmd_valid),
      .cmd_ready_o  (cmd_ready),
      .cmd_we_i     (cmd_we),
      .cmd_addr_i   (cmd_addr),
      .cmd_wdata_i  (cmd_wdata),
      .cmd_wstrb_i  (cmd_wstrb),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_rdata_o  (rsp_rdata),
      .rsp_status_o (rsp_status),
      .stray_o      (stray),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = wstrb;
      step();
      cmd_valid = 1'b0;
   endtask

   // Write with both address and data accepted at once; ends in WR_RESP.
   task automatic write_to_resp(input logic [31:0] addr, input logic [31:0] wdata);
      bus.awready = 1'b1; bus.wready = 1'b1;
      send_cmd(1'b1, addr, wdata, 4'hF);
      step();
      bus.awready = 1'b0; bus.wready = 1'b0;
   endtask

   // Read with immediate AR acceptance; ends in RD_DATA.
   task automatic read_to_data(input logic [31:0] addr);
      send_cmd(1'b0, addr, 32'h0, 4'h0);
      bus.arready = 1'b1;
      step();
      bus.arready = 1'b0;
   endtask

   task automatic take_rsp();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      areset = 1'b0;
      cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
      rsp_ready = 1'b0;
      bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
      bus.rid = '0; bus.rdata = '0; bus.rstrb = '0; bus.rlast = 1'b1; bus.rvalid = 1'b0;
      bus.bid = '0; bus.bresp = '0; bus.bvalid = 1'b0;
      step(); step();

      // Reset state
      chk_val("rst_awvalid", bus.awvalid, 0);
      chk_val("rst_wvalid",  bus.wvalid, 0);
      chk_val("rst_arvalid", bus.arvalid, 0);
      chk_val("rst_rspvld",  rsp_valid, 0);
      chk_val("rst_bready",  bus.bready, 1);
      chk_val("rst_rready",  bus.rready, 1);
      chk_val("rst_wlast",   bus.wlast, 1);
      chk_val("rst_status",  rsp_status, 0);
      chk_val("rst_stray",   stray, 0);
      areset = 1'b1;
      step();
      chk_val("idle_cmdrdy", cmd_ready, 1);

      // Write: awready after 2 cycles, wready immediately
      bus.wready = 1'b1;
      send_cmd(1'b1, 32'd3, 32'hDEADBEEF, 4'hF);
      chk_val("wr_awvalid", bus.awvalid, 1);
      chk_val("wr_wvalid",  bus.wvalid, 1);
      chk_val("wr_awaddr",  bus.awaddr, 32'd3);
      chk_val("wr_wdata",   bus.wdata, 32'hDEADBEEF);
      chk_val("wr_wstrb",   bus.wstrb, 4'hF);
      chk_val("wr_ids",     {bus.awid, bus.wid}, 8'h00);
      chk_val("wr_noar",    bus.arvalid, 0);
      chk_val("wr_cmdrdy",  cmd_ready, 0);
      step();
      bus.wready = 1'b0;
      chk_val("wr_w_drop",  bus.wvalid, 0);
      chk_val("wr_aw_hold", bus.awvalid, 1);
      step();
      chk_val("wr_aw_hold2", bus.awvalid, 1);
      bus.awready = 1'b1;
      step();
      bus.awready = 1'b0;
      chk_val("wr_aw_drop", bus.awvalid, 0);
      chk_val("wr_bready",  bus.bready, 1);
      chk_val("wr_norsp",   rsp_valid, 0);
      bus.bvalid = 1'b1; bus.bid = 4'h0; bus.bresp = 2'b00;
      step();
      bus.bvalid = 1'b0;
      chk_val("wr_rspvld",  rsp_valid, 1);
      chk_val("wr_status",  rsp_status, 2'b00);
      chk_val("wr_rdata",   rsp_rdata, 32'h0);
      chk_val("wr_rsp_bry", bus.bready, 0);
      take_rsp();
      chk_val("wr_idle",    cmd_ready, 1);

      // Read OK
      send_cmd(1'b0, 32'd3, 32'h0, 4'h0);
      chk_val("rd_arvalid", bus.arvalid, 1);
      chk_val("rd_araddr",  bus.araddr, 32'd3);
      chk_val("rd_noaw",    {bus.awvalid, bus.wvalid}, 2'b00);
      bus.arready = 1'b1;
      step();
      bus.arready = 1'b0;
      chk_val("rd_ar_drop", bus.arvalid, 0);
      chk_val("rd_rready",  bus.rready, 1);
      bus.rvalid = 1'b1; bus.rid = 4'h0; bus.rdata = 32'hDEADBEEF;
      step();
      bus.rvalid = 1'b0;
      chk_val("rd_rspvld",  rsp_valid, 1);
      chk_val("rd_rdata",   rsp_rdata, 32'hDEADBEEF);
      chk_val("rd_status",  rsp_status, 2'b00);
      chk_val("rd_rsp_rry", bus.rready, 0);
      take_rsp();

      // Write with SLVERR -> BUSERR
      write_to_resp(32'h10, 32'h12345678);
      bus.bvalid = 1'b1; bus.bresp = 2'b10;
      step();
      bus.bvalid = 1'b0; bus.bresp = 2'b00;
      chk_val("buserr_status", rsp_status, 2'b01);
      take_rsp();

      // Write with wrong BID -> IDERR
      write_to_resp(32'h11, 32'h0);
      bus.bvalid = 1'b1; bus.bid = 4'h3;
      step();
      bus.bvalid = 1'b0; bus.bid = 4'h0;
      chk_val("bid_iderr", rsp_status, 2'b10);
      take_rsp();

      // Read with wrong RID -> IDERR
      read_to_data(32'h5);
      bus.rvalid = 1'b1; bus.rid = 4'h5; bus.rdata = 32'hCAFEF00D;
      step();
      bus.rvalid = 1'b0; bus.rid = 4'h0;
      chk_val("rid_iderr", rsp_status, 2'b10);
      take_rsp();

      // Timeout: no B; response exactly 8 cycles after WR_RESP entry
      write_to_resp(32'h20, 32'hAAAA5555);
      n = 0;
      while (!rsp_valid && n < 20) begin
         step();
         n++;
      end
      chk_val("tmo_latency", n, 8);
      chk_val("tmo_status",  rsp_status, 2'b11);
      chk_val("tmo_rdata",   rsp_rdata, 32'h0);

      // Backpressure: hold response for 5 cycles
      for (int i = 0; i < 5; i++) begin
         step();
         chk_val("bp_stable", {rsp_valid, cmd_ready, rsp_status, rsp_rdata}, {1'b1, 1'b0, 2'b11, 32'h0});
      end
      take_rsp();
      chk_val("bp_release", {rsp_valid, cmd_ready}, 2'b01);

      // Late B drained in IDLE pulses stray once
      bus.bvalid = 1'b1;
      step();
      bus.bvalid = 1'b0;
      chk_val("stray_pulse", stray, 1);
      step();
      chk_val("stray_clear", stray, 0);
      chk_val("stray_norsp", rsp_valid, 0);

      // Beat arriving on the expiry cycle wins
      write_to_resp(32'h30, 32'h1);
      for (int i = 0; i < 7; i++) step();
      chk_val("edge_wait", rsp_valid, 0);
      bus.bvalid = 1'b1;
      step();
      bus.bvalid = 1'b0;
      chk_val("edge_rspvld", rsp_valid, 1);
      chk_val("edge_status", rsp_status, 2'b00);
      take_rsp();

      // Asynchronous reset mid-write
      send_cmd(1'b1, 32'h40, 32'h2, 4'h3);
      chk_val("ar_pre_aw", bus.awvalid, 1);
      areset = 1'b0;
      #1;
      chk_val("ar_valids", {bus.awvalid, bus.wvalid, bus.arvalid, rsp_valid}, 4'b0000);
      step(); step();
      areset = 1'b1;
      step();
      chk_val("ar_cmdrdy", cmd_ready, 1);
      step(); step();
      chk_val("ar_norsp", {rsp_valid, bus.awvalid}, 2'b00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
